// File: rtl/surfturf_cmd_framer.sv
// Packs one runcmd, trig and fw beat per fixed-length frame into a 32-bit command word
// for the rackbus serializer, and counts framed triggers.
module surfturf_cmd_framer #(
   parameter int FRAME_LEN   = 8,
   parameter int RUNCMD_BITS = 2,
   parameter int TRIG_BITS   = 15
) (
   input  logic                   sysclk_i,
   input  logic                   sysclk_rst_i,
   input  logic                   en_i,
   input  logic                   sync_i,
   input  logic [RUNCMD_BITS-1:0] runcmd_tdata,
   input  logic                   runcmd_tvalid,
   output logic                   runcmd_tready,
   input  logic [TRIG_BITS-1:0]   trig_tdata,
   input  logic                   trig_tvalid,
   output logic                   trig_tready,
   input  logic [7:0]             fw_tdata,
   input  logic                   fw_tvalid,
   output logic                   fw_tready,
   input  logic                   fw_mark_i,
   output logic                   fw_marked_o,
   output logic [31:0]            cmd_o,
   output logic                   cmd_valid_o,
   output logic [15:0]            trig_count_o
);

   localparam int CW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   cmd_q, word_d;
   logic          cmd_valid_q;
   logic [15:0]   trig_cnt_q, trig_cnt_d;
   logic          load, rdy, rc_x, tr_x, fw_x, mark;
   logic [1:0]    rc_ext;
   logic [14:0]   tr_ext;

   // Reset is folded into load so tready/marked drop the instant reset asserts.
   always_comb begin
      load   = (cnt_q == LAST) && !sync_i && !sysclk_rst_i;
      rdy    = load && en_i;
      rc_x   = rdy && runcmd_tvalid;
      tr_x   = rdy && trig_tvalid;
      fw_x   = rdy && fw_tvalid;
      mark   = rdy && fw_mark_i;
      rc_ext = 2'(runcmd_tdata);
      tr_ext = 15'(trig_tdata);
   end

   always_comb begin
      word_d        = '0;
      word_d[31:24] = fw_x ? fw_tdata : 8'h00;
      word_d[23]    = fw_x;
      word_d[22]    = mark;
      word_d[18]    = rc_x;
      word_d[17:16] = rc_x ? rc_ext : 2'b00;
      word_d[15]    = tr_x;
      word_d[14:0]  = tr_x ? tr_ext : 15'h0000;
      word_d[21]    = ^{word_d[31:22], word_d[20:0]};
   end

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (sync_i || cnt_q == LAST) cnt_d = '0;
      trig_cnt_d = trig_cnt_q + {15'd0, tr_x};
   end

   always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
      if (sysclk_rst_i) begin
         cnt_q       <= '0;
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
         trig_cnt_q  <= '0;
      end else begin
         cnt_q       <= cnt_d;
         cmd_valid_q <= load;
         trig_cnt_q  <= trig_cnt_d;
         if (load) cmd_q <= word_d;
      end
   end

   assign runcmd_tready = rdy;
   assign trig_tready   = rdy;
   assign fw_tready     = rdy;
   assign fw_marked_o   = mark;
   assign cmd_o         = cmd_q;
   assign cmd_valid_o   = cmd_valid_q;
   assign trig_count_o  = trig_cnt_q;

endmodule
